fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter ADDR_WIDTH, default 4: instruction memory word-address width.
REQ-002 Parameter DATA_WIDTH, default 32: instruction word width.
REQ-003 Parameter RESET_PC, default 32'h0000_0000: byte PC loaded on reset.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 fetchEn  input  1  high permits new memory reads.
REQ-007 redirect  input  1  one-cycle pulse; flush and restart at redirectPc.
REQ-008 redirectPc  input  32  new byte PC; bits [1:0] ignored and forced to 0.
REQ-009 memEn  output  ADDR_WIDTH-independent 1  instruction memory enable; equals memR.
REQ-010 memR  output  1  instruction memory read strobe.
REQ-011 memRAddr  output  ADDR_WIDTH  word address, equal to pc[ADDR_WIDTH+1:2].
REQ-012 memOut  input  DATA_WIDTH  memory read data, valid the cycle after memR (registered, non-fall-through memory).
REQ-013 instValid  output  1  the inst/instPc pair is valid.
REQ-014 instReady  input  1  consumer accepts; transfer when instValid and instReady are both high.
REQ-015 inst  output  DATA_WIDTH  instruction word.
REQ-016 instPc  output  32  byte PC of inst.

Function
REQ-017 Two-state FSM: IDLE and RUN. IDLE->RUN when fetchEn=1; RUN->IDLE when fetchEn=0; redirect does not change state.
REQ-018 Reads issue only in RUN and only when (fifoCount + inFlight - pop) < 2, where pop = instValid & instReady; memR is combinational from these terms.
REQ-019 On issue, memRAddr = pc[ADDR_WIDTH+1:2] and pc <= pc + 4 modulo 2^32; memRAddr wraps naturally from all-ones to 0.
REQ-020 A read issued at edge t sets inFlight for cycle t+1; memOut is pushed with its PC into a 2-entry FIFO at edge t+1; instValid is high from cycle t+2.
REQ-021 Issue-to-instValid latency is 2 cycles; sustained throughput is 1 instruction/cycle while instReady=1.
REQ-022 inst/instPc/instValid are driven from the FIFO head only; they are held stable while instValid=1 and instReady=0.
REQ-023 Redirect at cycle t: FIFO cleared at edge t; any in-flight response landing at t+1 is discarded; no read issued in cycle t; pc <= {redirectPc[31:2],2'b00}.
REQ-024 Redirect at cycle t: first read of the new PC issues in cycle t+1 (if RUN); instValid with the new instPc is first high in cycle t+3.
REQ-025 Redirect coincident with a handshake: the head transfer counts as consumed; all other entries are dropped.
REQ-026 fetchEn dropping: no new issue, in-flight response is still captured, buffered entries remain deliverable.
REQ-027 FIFO full (2 entries) with instReady=0: memR=0; no entry is ever overwritten or lost.

Reset
REQ-028 While rst=0: memR=0, memEn=0, instValid=0, inst=0, instPc=0, fifoCount=0, inFlight=0, pc=RESET_PC, state=IDLE.
REQ-029 rst assertion mid-operation discards all buffered and in-flight data immediately (asynchronous).
REQ-030 After rst deasserts with fetchEn=1, the first memR is issued in the first cycle in RUN, with address RESET_PC[ADDR_WIDTH+1:2].

Structure
REQ-031 Package fetch_pkg holds the FIFO depth constant (2), the fetch_state_t enum (IDLE, RUN), and the fetch_entry_t struct {pc, inst}.
REQ-032 FIFO is sub-module fetch_skid_fifo (depth 2, push/pop/flush, count output); the FSM, PC, and issue logic reside in fetch_unit.

Verification
REQ-033 Reset release with fetchEn=1 and instReady=1, memory word i = i: memRAddr sequence 0,1,2,...; instValid first high 2 cycles after the first memR; instPc sequence 0,4,8; inst values 0,1,2.
REQ-034 instReady=0 for 10 cycles: exactly 2 entries are buffered, memR is low after the fill, and on release inst values resume in order with no gap or duplicate.
REQ-035 Redirect to 32'h0000_0013 while in flight: stale words are never presented; next instPc = 32'h0000_0010, 3 cycles after redirect.
REQ-036 pc = {ADDR_WIDTH ones,2'b00} with ADDR_WIDTH=4 (pc = 0x3C): memRAddr goes 15 then 0.
REQ-037 rst pulsed low while 2 entries are buffered and 1 read is in flight: instValid=0 immediately; after release, the first instPc is RESET_PC.
REQ-038 fetchEn toggled low for 3 cycles: no memR is issued; the in-flight word is still delivered; the fetch resumes at the next sequential PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg
//   Shared definitions for the instruction fetch slice.
//   - FIFO_DEPTH / FIFO_PTR_W / FIFO_CNT_W : sizing of the response buffer
//   - FETCH_DATA_WIDTH                     : instruction width carried in a buffer entry
//   - fetch_state_t                        : fetch FSM states (IDLE, RUN)
//   - fetch_entry_t                        : one buffered response {pc, inst}
//   - ENTRY_W                              : flat width of fetch_entry_t for port transport
//   - align_pc()                           : force a byte PC onto a word boundary
package fetch_pkg;

   localparam int FIFO_DEPTH       = 2;
   localparam int FIFO_PTR_W       = $clog2(FIFO_DEPTH);
   localparam int FIFO_CNT_W       = $clog2(FIFO_DEPTH + 1);
   localparam int FETCH_DATA_WIDTH = 32;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } fetch_state_t;

   typedef struct packed {
      logic [31:0]                 pc;
      logic [FETCH_DATA_WIDTH-1:0] inst;
   } fetch_entry_t;

   localparam int ENTRY_W = $bits(fetch_entry_t);

   function automatic logic [31:0] align_pc(input logic [31:0] pc);
      return {pc[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_skid_fifo.sv
// fetch_skid_fifo
//   Two-entry response buffer between the instruction memory and the consumer.
//   The head entry is always visible on o_head; o_count tells how many entries
//   are valid.
//   Ports:
//     clk          : clock, rising edge
//     rst          : asynchronous active-low reset, empties the buffer
//     i_push       : write i_push_entry at the tail
//     i_push_entry : flattened fetch_entry_t to store
//     i_pop        : drop the head entry
//     i_flush      : discard every entry (wins over push and pop)
//     o_head       : flattened fetch_entry_t at the head
//     o_count      : number of valid entries (0..FIFO_DEPTH)
module fetch_skid_fifo
   import fetch_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_push,
   input  logic [ENTRY_W-1:0]    i_push_entry,
   input  logic                  i_pop,
   input  logic                  i_flush,
   output logic [ENTRY_W-1:0]    o_head,
   output logic [FIFO_CNT_W-1:0] o_count
);

   logic [ENTRY_W-1:0]    r_entry [FIFO_DEPTH];
   logic [FIFO_PTR_W-1:0] r_wr_ptr;
   logic [FIFO_PTR_W-1:0] r_rd_ptr;
   logic [FIFO_CNT_W-1:0] r_count;
   logic                  w_do_push;
   logic                  w_do_pop;

   // A pop on an empty buffer is ignored. A push into a full buffer is only
   // accepted when the head leaves on the same edge, so nothing is ever lost.
   assign w_do_pop  = i_pop && (r_count != '0);
   assign w_do_push = i_push && ((r_count != FIFO_CNT_W'(FIFO_DEPTH)) || w_do_pop);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            r_entry[i] <= '0;
         end
      end else if (w_do_push && !i_flush) begin
         r_entry[r_wr_ptr] <= i_push_entry;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) begin
            r_wr_ptr <= r_wr_ptr + FIFO_PTR_W'(1);
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + FIFO_PTR_W'(1);
         end
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + FIFO_CNT_W'(1);
            2'b01:   r_count <= r_count - FIFO_CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_head  = r_entry[r_rd_ptr];
   assign o_count = r_count;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit
//   Sequential instruction fetcher with redirect support. Issues word reads to
//   a registered (one-cycle latency) instruction memory, buffers up to two
//   responses and presents them on a valid/ready interface.
//   Ports:
//     clk        : clock, rising edge
//     rst        : asynchronous active-low reset
//     fetchEn    : permits new memory reads
//     redirect   : one-cycle pulse, flush and restart at redirectPc
//     redirectPc : new byte PC (bits [1:0] ignored)
//     memEn      : memory enable, identical to memR
//     memR       : memory read strobe
//     memRAddr   : memory word address, pc[ADDR_WIDTH+1:2]
//     memOut     : memory read data, valid the cycle after memR
//     instValid  : inst/instPc hold a valid instruction
//     instReady  : consumer accepts the instruction this cycle
//     inst       : instruction word
//     instPc     : byte PC of inst
//   DATA_WIDTH must not exceed FETCH_DATA_WIDTH, the width a buffer entry carries.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int          ADDR_WIDTH = 4,
   parameter int          DATA_WIDTH = 32,
   parameter logic [31:0] RESET_PC   = 32'h0000_0000
)
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  fetchEn,
   input  logic                  redirect,
   input  logic [31:0]           redirectPc,
   output logic                  memEn,
   output logic                  memR,
   output logic [ADDR_WIDTH-1:0] memRAddr,
   input  logic [DATA_WIDTH-1:0] memOut,
   output logic                  instValid,
   input  logic                  instReady,
   output logic [DATA_WIDTH-1:0] inst,
   output logic [31:0]           instPc
);

   fetch_state_t          r_state;
   logic [31:0]           r_pc;
   logic                  r_in_flight;
   logic [31:0]           r_in_flight_pc;

   logic [FIFO_CNT_W-1:0] w_fifo_count;
   logic [FIFO_CNT_W:0]   w_occupancy;
   logic [ENTRY_W-1:0]    w_head_raw;
   logic [ENTRY_W-1:0]    w_push_raw;
   fetch_entry_t          w_head;
   fetch_entry_t          w_push_entry;
   logic                  w_pop;
   logic                  w_push;
   logic                  w_issue;

   assign w_pop = instValid & instReady;

   // Slots that will be committed after this edge: buffered entries plus the
   // response on its way, minus the head leaving now. A new read is allowed
   // only if its response is guaranteed a slot when it lands.
   assign w_occupancy = {1'b0, w_fifo_count}
                      + {{FIFO_CNT_W{1'b0}}, r_in_flight}
                      - {{FIFO_CNT_W{1'b0}}, w_pop};

   assign w_issue = (r_state == RUN) && fetchEn && !redirect
                    && (w_occupancy < (FIFO_CNT_W + 1)'(FIFO_DEPTH));

   assign memR     = w_issue;
   assign memEn    = w_issue;
   assign memRAddr = r_pc[ADDR_WIDTH+1:2];

   // A response landing in the redirect cycle belongs to the old stream.
   assign w_push = r_in_flight && !redirect;

   always_comb begin
      w_push_entry      = '0;
      w_push_entry.pc   = r_in_flight_pc;
      w_push_entry.inst = FETCH_DATA_WIDTH'(memOut);
   end

   assign w_push_raw = w_push_entry;
   assign w_head     = fetch_entry_t'(w_head_raw);

   fetch_skid_fifo u_fifo (
      .clk          (clk),
      .rst          (rst),
      .i_push       (w_push),
      .i_push_entry (w_push_raw),
      .i_pop        (w_pop),
      .i_flush      (redirect),
      .o_head       (w_head_raw),
      .o_count      (w_fifo_count)
   );

   assign instValid = (w_fifo_count != '0);
   assign inst      = instValid ? DATA_WIDTH'(w_head.inst) : '0;
   assign instPc    = instValid ? w_head.pc : '0;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state        <= IDLE;
         r_pc           <= RESET_PC;
         r_in_flight    <= 1'b0;
         r_in_flight_pc <= '0;
      end else begin
         case (r_state)
            IDLE:    if (fetchEn)  r_state <= RUN;
            RUN:     if (!fetchEn) r_state <= IDLE;
            default: r_state <= IDLE;
         endcase

         if (redirect) begin
            r_pc <= align_pc(redirectPc);
         end else if (w_issue) begin
            r_pc <= r_pc + 32'd4;
         end

         r_in_flight <= w_issue;
         if (w_issue) begin
            r_in_flight_pc <= r_pc;
         end
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

   localparam int          AW  = 4;
   localparam int          DW  = 32;
   localparam logic [31:0] RPC = 32'h0000_0000;

   logic          clk = 1'b0;
   logic          rst;
   logic          fetchEn;
   logic          redirect;
   logic [31:0]   redirectPc;
   logic          memEn;
   logic          memR;
   logic [AW-1:0] memRAddr;
   logic [DW-1:0] memOut;
   logic          instValid;
   logic          instReady;
   logic [DW-1:0] inst;
   logic [31:0]   instPc;

   logic [31:0]   mem [16];
   int            n_checks = 0;
   int            n_errors = 0;
   logic [31:0]   exp_pc;

   fetch_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RESET_PC(RPC)) dut (
      .clk        (clk),
      .rst        (rst),
      .fetchEn    (fetchEn),
      .redirect   (redirect),
      .redirectPc (redirectPc),
      .memEn      (memEn),
      .memR       (memR),
      .memRAddr   (memRAddr),
      .memOut     (memOut),
      .instValid  (instValid),
      .instReady  (instReady),
      .inst       (inst),
      .instPc     (instPc)
   );

   always #5 clk = ~clk;

   // Registered instruction memory: data appears the cycle after the read.
   always @(posedge clk) begin
      if (memR) memOut <= mem[memRAddr];
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0; fetchEn = 1'b1; instReady = 1'b1; redirect = 1'b0; redirectPc = '0;
      repeat (3) cyc();
      @(negedge clk);
      n_checks++; if (memR !== 1'b0) begin n_errors++; $display("FAIL reset_memR: got %b want 0", memR); end
      n_checks++; if (memEn !== 1'b0) begin n_errors++; $display("FAIL reset_memEn: got %b want 0", memEn); end
      n_checks++; if (instValid !== 1'b0) begin n_errors++; $display("FAIL reset_instValid: got %b want 0", instValid); end
      n_checks++; if (inst !== '0) begin n_errors++; $display("FAIL reset_inst: got %h want 0", inst); end
      n_checks++; if (instPc !== '0) begin n_errors++; $display("FAIL reset_instPc: got %h want 0", instPc); end
      n_checks++; if (memRAddr !== RPC[AW+1:2]) begin n_errors++; $display("FAIL reset_memRAddr: got %0d want %0d", memRAddr, RPC[AW+1:2]); end
   endtask

   // Release reset with fetchEn=1, instReady=1, memory word i = i.
   task automatic test_stream();
      for (int i = 0; i < 16; i++) mem[i] = i;
      cyc();
      rst = 1'b1;
      for (int c = 0; c < 12; c++) begin
         if (c > 0) cyc();
         @(negedge clk);
         n_checks++; if (memR !== (c >= 1)) begin n_errors++; $display("FAIL stream_memR c=%0d: got %b want %b", c, memR, (c >= 1)); end
         if (c >= 1) begin
            n_checks++; if (memRAddr !== AW'(c - 1)) begin n_errors++; $display("FAIL stream_addr c=%0d: got %0d want %0d", c, memRAddr, c - 1); end
         end
         n_checks++; if (instValid !== (c >= 3)) begin n_errors++; $display("FAIL stream_valid c=%0d: got %b want %b", c, instValid, (c >= 3)); end
         if (c >= 3) begin
            n_checks++; if (instPc !== 32'(4 * (c - 3))) begin n_errors++; $display("FAIL stream_pc c=%0d: got %h want %h", c, instPc, 32'(4 * (c - 3))); end
            n_checks++; if (inst !== 32'(c - 3)) begin n_errors++; $display("FAIL stream_inst c=%0d: got %h want %h", c, inst, 32'(c - 3)); end
            $display("stream deliver pc=%h inst=%h", instPc, inst);
         end
      end
      exp_pc = 32'(4 * 9);
   endtask

   task automatic test_backpressure();
      logic [31:0]   hold_inst;
      logic [31:0]   hold_pc;
      logic [AW-1:0] next_addr;
      cyc();
      instReady = 1'b0;
      @(negedge clk);
      hold_inst = inst; hold_pc = instPc;
      n_checks++; if (instPc !== exp_pc) begin n_errors++; $display("FAIL bp_head_pc: got %h want %h", instPc, exp_pc); end
      for (int k = 1; k < 10; k++) begin
         cyc();
         @(negedge clk);
         n_checks++; if (instValid !== 1'b1) begin n_errors++; $display("FAIL bp_valid k=%0d: got %b want 1", k, instValid); end
         n_checks++; if (inst !== hold_inst || instPc !== hold_pc) begin n_errors++; $display("FAIL bp_stable k=%0d: got %h@%h want %h@%h", k, inst, instPc, hold_inst, hold_pc); end
         n_checks++; if (memR !== 1'b0) begin n_errors++; $display("FAIL bp_memR k=%0d: got %b want 0", k, memR); end
      end
      next_addr = exp_pc[AW+1:2] + AW'(2);
      for (int k = 0; k < 8; k++) begin
         cyc();
         instReady = 1'b1;
         @(negedge clk);
         if (k == 0) begin
            n_checks++; if (memR !== 1'b1 || memRAddr !== next_addr) begin n_errors++; $display("FAIL bp_resume_read: got %b@%0d want 1@%0d", memR, memRAddr, next_addr); end
         end
         n_checks++; if (instValid !== 1'b1) begin n_errors++; $display("FAIL bp_release_valid k=%0d: got %b want 1", k, instValid); end
         n_checks++; if (instPc !== exp_pc || inst !== mem[exp_pc[AW+1:2]]) begin n_errors++; $display("FAIL bp_release_data k=%0d: got %h@%h want %h@%h", k, inst, instPc, mem[exp_pc[AW+1:2]], exp_pc); end
         $display("bp deliver pc=%h inst=%h", instPc, inst);
         exp_pc = exp_pc + 4;
      end
   endtask

   task automatic test_redirect();
      cyc();
      redirect = 1'b1; redirectPc = 32'h0000_0013;
      @(negedge clk);
      n_checks++; if (memR !== 1'b0) begin n_errors++; $display("FAIL redir_no_issue: got %b want 0", memR); end
      n_checks++; if (instValid !== 1'b1 || instPc !== exp_pc) begin n_errors++; $display("FAIL redir_head: got %b@%h want 1@%h", instValid, instPc, exp_pc); end
      exp_pc = 32'h0000_0010;
      cyc();
      redirect = 1'b0;
      @(negedge clk);
      n_checks++; if (instValid !== 1'b0) begin n_errors++; $display("FAIL redir_stale1: got %b@%h want 0", instValid, instPc); end
      n_checks++; if (memR !== 1'b1 || memRAddr !== AW'(4)) begin n_errors++; $display("FAIL redir_first_read: got %b@%0d want 1@4", memR, memRAddr); end
      cyc();
      @(negedge clk);
      n_checks++; if (instValid !== 1'b0) begin n_errors++; $display("FAIL redir_stale2: got %b@%h want 0", instValid, instPc); end
      for (int k = 0; k < 4; k++) begin
         cyc();
         @(negedge clk);
         n_checks++; if (instValid !== 1'b1 || instPc !== exp_pc || inst !== mem[exp_pc[AW+1:2]]) begin n_errors++; $display("FAIL redir_data k=%0d: got %b %h@%h want 1 %h@%h", k, instValid, inst, instPc, mem[exp_pc[AW+1:2]], exp_pc); end
         $display("redir deliver pc=%h inst=%h", instPc, inst);
         exp_pc = exp_pc + 4;
      end
   endtask

   task automatic test_wrap();
      cyc();
      redirect = 1'b1; redirectPc = 32'h0000_003C;
      @(negedge clk);
      n_checks++; if (instValid !== 1'b1 || instPc !== exp_pc) begin n_errors++; $display("FAIL wrap_head: got %b@%h want 1@%h", instValid, instPc, exp_pc); end
      exp_pc = 32'h0000_003C;
      cyc();
      redirect = 1'b0;
      @(negedge clk);
      n_checks++; if (memR !== 1'b1 || memRAddr !== AW'(15)) begin n_errors++; $display("FAIL wrap_addr15: got %b@%0d want 1@15", memR, memRAddr); end
      cyc();
      @(negedge clk);
      n_checks++; if (memR !== 1'b1 || memRAddr !== AW'(0)) begin n_errors++; $display("FAIL wrap_addr0: got %b@%0d want 1@0", memR, memRAddr); end
      for (int k = 0; k < 2; k++) begin
         cyc();
         @(negedge clk);
         n_checks++; if (instValid !== 1'b1 || instPc !== exp_pc || inst !== mem[exp_pc[AW+1:2]]) begin n_errors++; $display("FAIL wrap_data k=%0d: got %b %h@%h want 1 %h@%h", k, instValid, inst, instPc, mem[exp_pc[AW+1:2]], exp_pc); end
         $display("wrap deliver pc=%h inst=%h", instPc, inst);
         exp_pc = exp_pc + 4;
      end
   endtask

   task automatic test_fetch_pause();
      int delivered = 0;
      bit found = 1'b0;
      for (int k = 0; k < 3; k++) begin
         cyc();
         fetchEn = 1'b0;
         @(negedge clk);
         n_checks++; if (memR !== 1'b0) begin n_errors++; $display("FAIL pause_memR k=%0d: got %b want 0", k, memR); end
         if (instValid) begin
            n_checks++; if (instPc !== exp_pc || inst !== mem[exp_pc[AW+1:2]]) begin n_errors++; $display("FAIL pause_data k=%0d: got %h@%h want %h@%h", k, inst, instPc, mem[exp_pc[AW+1:2]], exp_pc); end
            $display("pause deliver pc=%h inst=%h", instPc, inst);
            exp_pc = exp_pc + 4;
            delivered++;
         end
      end
      n_checks++; if (delivered != 2) begin n_errors++; $display("FAIL pause_drain: got %0d deliveries want 2", delivered); end
      for (int k = 0; k < 6; k++) begin
         cyc();
         fetchEn = 1'b1;
         @(negedge clk);
         if (memR && !found) begin
            found = 1'b1;
            n_checks++; if (memRAddr !== exp_pc[AW+1:2]) begin n_errors++; $display("FAIL pause_resume_addr: got %0d want %0d", memRAddr, exp_pc[AW+1:2]); end
         end
         if (instValid) begin
            n_checks++; if (instPc !== exp_pc || inst !== mem[exp_pc[AW+1:2]]) begin n_errors++; $display("FAIL resume_data k=%0d: got %h@%h want %h@%h", k, inst, instPc, mem[exp_pc[AW+1:2]], exp_pc); end
            $display("resume deliver pc=%h inst=%h", instPc, inst);
            exp_pc = exp_pc + 4;
         end
      end
      n_checks++; if (found !== 1'b1) begin n_errors++; $display("FAIL pause_resume_timeout: got no read want one"); end
   endtask

   task automatic test_reset_midop();
      bit found = 1'b0;
      cyc();
      instReady = 1'b0;
      @(negedge clk);
      n_checks++; if (instValid !== 1'b1) begin n_errors++; $display("FAIL midrst_pre_valid: got %b want 1", instValid); end
      rst = 1'b0;
      #1;
      n_checks++; if (instValid !== 1'b0 || inst !== '0 || instPc !== '0) begin n_errors++; $display("FAIL midrst_flush: got %b %h@%h want 0 0@0", instValid, inst, instPc); end
      n_checks++; if (memR !== 1'b0) begin n_errors++; $display("FAIL midrst_memR: got %b want 0", memR); end
      cyc();
      @(negedge clk);
      n_checks++; if (instValid !== 1'b0) begin n_errors++; $display("FAIL midrst_hold: got %b want 0", instValid); end
      instReady = 1'b1; fetchEn = 1'b1;
      cyc();
      rst = 1'b1;
      exp_pc = RPC;
      for (int k = 0; k < 8; k++) begin
         if (k > 0) cyc();
         @(negedge clk);
         if (instValid && !found) begin
            found = 1'b1;
            n_checks++; if (instPc !== exp_pc || inst !== mem[exp_pc[AW+1:2]]) begin n_errors++; $display("FAIL midrst_first: got %h@%h want %h@%h", inst, instPc, mem[exp_pc[AW+1:2]], exp_pc); end
            $display("midrst deliver pc=%h inst=%h", instPc, inst);
         end
      end
      n_checks++; if (found !== 1'b1) begin n_errors++; $display("FAIL midrst_timeout: got no instruction want one"); end
   endtask

   // Random enable, backpressure and redirects against a stream model:
   // reads walk upward from the last redirect target, deliveries must follow
   // the same order, and a held instruction never changes.
   task automatic test_random();
      logic [31:0] issue_pc;
      logic [31:0] hold_inst;
      logic [31:0] hold_pc;
      bit          prev_hold = 1'b0;
      rst = 1'b0; fetchEn = 1'b0; instReady = 1'b0; redirect = 1'b0;
      cyc(); cyc();
      for (int i = 0; i < 16; i++) mem[i] = $urandom;
      rst = 1'b1;
      exp_pc = RPC; issue_pc = RPC; hold_inst = '0; hold_pc = '0;
      for (int c = 0; c < 400; c++) begin
         cyc();
         fetchEn    = ($urandom_range(99) < 85);
         instReady  = ($urandom_range(99) < 60);
         redirect   = ($urandom_range(99) < 6);
         redirectPc = $urandom;
         @(negedge clk);
         n_checks++; if (memEn !== memR) begin n_errors++; $display("FAIL rnd_memEn c=%0d: got %b want %b", c, memEn, memR); end
         if (redirect) begin
            n_checks++; if (memR !== 1'b0) begin n_errors++; $display("FAIL rnd_redir_issue c=%0d: got %b want 0", c, memR); end
         end else if (memR) begin
            n_checks++; if (fetchEn !== 1'b1) begin n_errors++; $display("FAIL rnd_issue_disabled c=%0d: got memR=1 want 0", c); end
            n_checks++; if (memRAddr !== issue_pc[AW+1:2]) begin n_errors++; $display("FAIL rnd_addr c=%0d: got %0d want %0d", c, memRAddr, issue_pc[AW+1:2]); end
            issue_pc = issue_pc + 4;
         end
         if (prev_hold) begin
            n_checks++; if (instValid !== 1'b1 || inst !== hold_inst || instPc !== hold_pc) begin n_errors++; $display("FAIL rnd_hold c=%0d: got %b %h@%h want 1 %h@%h", c, instValid, inst, instPc, hold_inst, hold_pc); end
         end
         if (instValid && instReady) begin
            n_checks++; if (instPc !== exp_pc || inst !== mem[exp_pc[AW+1:2]]) begin n_errors++; $display("FAIL rnd_data c=%0d: got %h@%h want %h@%h", c, inst, instPc, mem[exp_pc[AW+1:2]], exp_pc); end
            $display("rnd deliver pc=%h inst=%h", instPc, inst);
            exp_pc = exp_pc + 4;
         end
         if (redirect) begin
            exp_pc   = {redirectPc[31:2], 2'b00};
            issue_pc = {redirectPc[31:2], 2'b00};
         end
         prev_hold = instValid && !instReady && !redirect;
         hold_inst = inst;
         hold_pc   = instPc;
      end
      redirect = 1'b0;
   endtask

   initial begin
      rst = 1'b0; fetchEn = 1'b0; redirect = 1'b0; redirectPc = '0; instReady = 1'b0;
      for (int i = 0; i < 16; i++) mem[i] = '0;
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect();
      test_wrap();
      test_fetch_pause();
      test_reset_midop();
      test_random();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
